// File: rtl/idct_pkg.sv
// Shared definitions for the 32-point IDCT odd-part engine: widths, FSM states,
// odd-row coefficient magnitudes and the (j,k) -> sign/magnitude-index mapping.
package idct_pkg;

    localparam int IDCT_IN_W  = 16;
    localparam int IDCT_ACC_W = 27;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Magnitudes C[1], C[3], ... C[31]; entry i holds C[2i+1].
    localparam int COEF_MAG [16] = '{90, 90, 88, 85, 82, 78, 73, 67,
                                     61, 54, 46, 38, 31, 22, 13, 4};

    typedef struct packed {
        logic       neg;
        logic [3:0] idx;
    } coef_sel_t;

    // T[2j+1][k] = sign * C[q], folded from the quadrant of p = (2k+1)(2j+1) mod 128.
    function automatic coef_sel_t coef_sel(input logic [3:0] j, input logic [3:0] k);
        logic [9:0] m;
        logic [6:0] p;
        logic [7:0] q;
        coef_sel_t  s;
        m = {5'd0, k, 1'b1} * {5'd0, j, 1'b1};
        p = 7'(m);
        if (p < 7'd32) begin
            s.neg = 1'b0;
            q     = {1'b0, p};
        end else if (p < 7'd64) begin
            s.neg = 1'b1;
            q     = 8'd64 - {1'b0, p};
        end else if (p < 7'd96) begin
            s.neg = 1'b1;
            q     = {1'b0, p} - 8'd64;
        end else begin
            s.neg = 1'b0;
            q     = 8'd128 - {1'b0, p};
        end
        s.idx = 4'((q - 8'd1) >> 1);
        return s;
    endfunction

endpackage

// File: rtl/idct32_odd_acc_if.sv
// Coefficient-in / O[k]-out stream bundle for idct32_odd_acc.
interface idct32_odd_acc_if
    import idct_pkg::*;
#(
    parameter int IN_W  = IDCT_IN_W,
    parameter int ACC_W = IDCT_ACC_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [3:0]              out_idx;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/idct_mcm16.sv
// Shift-add multiple-constant multiplier: prod[i] = x_in * C[2i+1] for the
// 16 odd-row DCT magnitudes, sharing the power-of-two partial terms.
module idct_mcm16 #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 27
) (
    input  logic signed [IN_W-1:0]  x_in,
    output logic signed [ACC_W-1:0] prod [16]
);
    logic signed [ACC_W-1:0] x1, x2, x4, x8, x16, x32, x64;

    assign x1  = {{(ACC_W-IN_W){x_in[IN_W-1]}}, x_in};
    assign x2  = x1 <<< 1;
    assign x4  = x1 <<< 2;
    assign x8  = x1 <<< 3;
    assign x16 = x1 <<< 4;
    assign x32 = x1 <<< 5;
    assign x64 = x1 <<< 6;

    assign prod[0]  = x64 + x16 + x8 + x2;
    assign prod[1]  = prod[0];
    assign prod[2]  = x64 + x16 + x8;
    assign prod[3]  = x64 + x16 + x4 + x1;
    assign prod[4]  = x64 + x16 + x2;
    assign prod[5]  = x64 + x16 - x2;
    assign prod[6]  = x64 + x8 + x1;
    assign prod[7]  = x64 + x2 + x1;
    assign prod[8]  = x64 - x2 - x1;
    assign prod[9]  = x64 - x8 - x2;
    assign prod[10] = x32 + x16 - x2;
    assign prod[11] = x32 + x4 + x2;
    assign prod[12] = x32 - x1;
    assign prod[13] = x16 + x4 + x2;
    assign prod[14] = x8 + x4 + x1;
    assign prod[15] = x4;
endmodule

// File: rtl/idct32_odd_acc.sv
// Odd-part engine of the 32-point inverse DCT: accumulates O[k] over 16 serial
// coefficients, then streams O[0..15]. Optional feature macro: IDCT_ODD_EARLY_LAST_EN.
module idct32_odd_acc
    import idct_pkg::*;
#(
    parameter int IN_W  = IDCT_IN_W,
    parameter int ACC_W = IDCT_ACC_W
) (
    input logic             clk,
    input logic             rst_n,
    idct32_odd_acc_if.slave bus
);
    state_e                  state_q, state_d;
    logic [3:0]              beat_q, beat_d;
    logic [3:0]              out_idx_q, out_idx_d;
    logic signed [ACC_W-1:0] acc_q [16];
    logic signed [ACC_W-1:0] acc_d [16];
    logic signed [ACC_W-1:0] prod [16];
    logic                    accept;
    logic                    last_beat;

    idct_mcm16 #(.IN_W(IN_W), .ACC_W(ACC_W)) u_mcm (
        .x_in (bus.in_data),
        .prod (prod)
    );

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_data  = acc_q[out_idx_q];
    assign bus.out_idx   = out_idx_q;
    assign accept        = bus.in_valid && (state_q == ST_ACCUM);

`ifdef IDCT_ODD_EARLY_LAST_EN
    assign last_beat = (beat_q == 4'd15) || bus.in_last;
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
    assign last_beat      = (beat_q == 4'd15);
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        out_idx_d = out_idx_q;
        case (state_q)
            ST_WAIT: state_d = ST_ACCUM;
            ST_ACCUM: begin
                if (accept) begin
                    beat_d = beat_q + 4'd1;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                        beat_d  = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    out_idx_d = out_idx_q + 4'd1;
                    if (out_idx_q == 4'd15) begin
                        state_d   = ST_ACCUM;
                        out_idx_d = '0;
                        beat_d    = '0;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Beat 0 overwrites so no clear cycle is needed between blocks.
    always_comb begin
        coef_sel_t               sel;
        logic signed [ACC_W-1:0] term;
        acc_d = acc_q;
        for (int k = 0; k < 16; k++) begin
            sel  = coef_sel(beat_q, 4'(k));
            term = sel.neg ? -prod[sel.idx] : prod[sel.idx];
            if (accept) begin
                acc_d[k] = ((beat_q == 4'd0) ? '0 : acc_q[k]) + term;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT;
            beat_q    <= '0;
            out_idx_q <= '0;
            for (int k = 0; k < 16; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            out_idx_q <= out_idx_d;
            acc_q     <= acc_d;
        end
    end
endmodule

// File: tb/tb_idct32_odd_acc.sv
// Self-checking bench for idct32_odd_acc: table-driven blocks scored through an
// expected-output queue, plus backpressure, mid-block reset and in_last sequences.
module tb_idct32_odd_acc;
    localparam int IN_W  = 16;
    localparam int ACC_W = 27;

    typedef struct {
        logic [15:0][IN_W-1:0]  d;
        logic [15:0][ACC_W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   expData [$];
    int   expIdx  [$];
    vec_t vecs [5];
    int   ctab [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    int   row1 [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    int   row3 [16] = '{90, 82, 67, 46, 22, -4, -31, -54, -73, -85, -90, -88, -78, -61, -38, -13};

    idct32_odd_acc_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    idct32_odd_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int coefT(input int j, input int k);
        int p;
        p = ((2 * k + 1) * (2 * j + 1)) % 128;
        if (p < 32) return ctab[(p - 1) / 2];
        if (p < 64) return -ctab[(64 - p - 1) / 2];
        if (p < 96) return -ctab[(p - 64 - 1) / 2];
        return ctab[(128 - p - 1) / 2];
    endfunction

    function automatic logic [15:0][ACC_W-1:0] model(input logic [15:0][IN_W-1:0] d);
        logic [15:0][ACC_W-1:0] r;
        int sum;
        for (int k = 0; k < 16; k++) begin
            sum = 0;
            for (int j = 0; j < 16; j++) begin
                sum += coefT(j, k) * int'($signed(d[j]));
            end
            r[k] = sum[ACC_W-1:0];
        end
        return r;
    endfunction

    task automatic pushExpected(input logic [15:0][ACC_W-1:0] e);
        for (int k = 0; k < 16; k++) begin
            expData.push_back(int'($signed(e[k])));
            expIdx.push_back(k);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic driveBeat(input logic [IN_W-1:0] data, input logic last);
        int waitCnt;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        waitCnt      = 0;
        while (!bus.in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 100) checkOutput("in_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0][IN_W-1:0] d, input int nbeats, input logic lastFlag);
        for (int j = 0; j < nbeats; j++) begin
            driveBeat(d[j], lastFlag && (j == nbeats - 1));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while ((expData.size() != 0) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 300) checkOutput("drain_timeout", expData.size(), 0);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, int'(bus.in_ready), 0);
        checkOutput({tag, "_out_valid"}, int'(bus.out_valid), 0);
        checkOutput({tag, "_out_data"}, int'($signed(bus.out_data)), 0);
        checkOutput({tag, "_out_idx"}, int'(bus.out_idx), 0);
    endtask

    always begin
        int eD;
        int eI;
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expData.size() == 0) begin
                checkOutput("unexpected_out", 1, 0);
            end else begin
                eD = expData.pop_front();
                eI = expIdx.pop_front();
                checkOutput("out_data", int'($signed(bus.out_data)), eD);
                checkOutput("out_idx", int'(bus.out_idx), eI);
            end
        end
    end

    initial begin
        logic [15:0][IN_W-1:0] zeroD;
        logic [15:0][IN_W-1:0] rndD;
        int pat [4] = '{1, 0, 0, 1};
        int heldData;
        int heldIdx;
        bit prevStall;
        bit done;

        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        zeroD         = '0;

        for (int i = 0; i < 5; i++) vecs[i].d = '0;
        vecs[0].d[0] = 16'sd1;
        vecs[1].d[1] = 16'sd1;
        for (int k = 0; k < 16; k++) begin
            vecs[0].exp[k] = ACC_W'(row1[k]);
            vecs[1].exp[k] = ACC_W'(row3[k]);
            vecs[2].d[k]   = 16'h8000;
            vecs[3].d[k]   = IN_W'($urandom);
            vecs[4].d[k]   = IN_W'($urandom_range(0, 600)) - 16'sd300;
        end
        vecs[2].exp    = model(vecs[2].d);
        vecs[2].exp[0] = ACC_W'(-30212096);
        vecs[3].exp    = model(vecs[3].d);
        vecs[4].exp    = model(vecs[4].d);

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pushExpected(vecs[i].exp);
            applyStimulus(vecs[i].d, 16, 1'b0);
            waitDrain();
        end

        // Backpressure during DRAIN with the next block's first beat already offered.
        pushExpected(vecs[1].exp);
        applyStimulus(vecs[1].d, 16, 1'b0);
        checkOutput("first_out_latency", int'(bus.out_valid), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd1;
        bus.in_last  = 1'b0;
        prevStall    = 1'b0;
        done         = 1'b0;
        heldData     = 0;
        heldIdx      = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (prevStall) begin
                checkOutput("stall_data", int'($signed(bus.out_data)), heldData);
                checkOutput("stall_idx", int'(bus.out_idx), heldIdx);
            end
            checkOutput("in_ready_drain", int'(bus.in_ready), 0);
            bus.out_ready = pat[cyc % 4][0];
            prevStall     = bus.out_valid && !bus.out_ready;
            heldData      = int'($signed(bus.out_data));
            heldIdx       = int'(bus.out_idx);
            done          = bus.out_valid && bus.out_ready && (bus.out_idx == 4'd15);
            @(negedge clk);
        end
        checkOutput("bp_drain_done", int'(done), 1);
        bus.out_ready = 1'b1;
        checkOutput("in_ready_after_drain", int'(bus.in_ready), 1);
        pushExpected(vecs[0].exp);
        @(negedge clk);
        for (int j = 1; j < 16; j++) driveBeat('0, 1'b0);
        bus.in_valid = 1'b0;
        waitDrain();

        // Reset in the middle of a block discards the partial sums.
        for (int k = 0; k < 16; k++) rndD[k] = IN_W'($urandom);
        applyStimulus(rndD, 8, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pushExpected(vecs[0].exp);
        applyStimulus(vecs[0].d, 16, 1'b0);
        waitDrain();

        // in_last on beat 0.
`ifdef IDCT_ODD_EARLY_LAST_EN
        pushExpected(vecs[0].exp);
        driveBeat(16'sd1, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checkOutput("early_last_drain", int'(bus.out_valid), 1);
        waitDrain();
`else
        driveBeat(16'sd1, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (5) begin
            checkOutput("no_early_drain", int'(bus.out_valid), 0);
            checkOutput("still_accum", int'(bus.in_ready), 1);
            @(negedge clk);
        end
        pushExpected(vecs[0].exp);
        for (int j = 1; j < 16; j++) driveBeat(zeroD[j], 1'b0);
        bus.in_valid = 1'b0;
        waitDrain();
`endif

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", expData.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
